// File: rtl/adc_sampler_pkg.sv
// Shared loctag ADC definitions: sampler FSM encoding, serial frame geometry and the
// default envelope thresholds that the loctag core also uses.
package adc_sampler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StQuiet
  } state_e;

  localparam int unsigned FrameBits = 16;
  localparam int unsigned DataBits  = 12;

  localparam logic [11:0] ThreshHiDefault = 12'd2048;
  localparam logic [11:0] ThreshLoDefault = 12'd1536;

endpackage

// File: rtl/adc_hyst_cmp.sv
// Registered set/clear hysteresis comparator producing the loctag envelope flag.
module adc_hyst_cmp
  import adc_sampler_pkg::*;
#(
  parameter int unsigned          DATA_BITS = DataBits,
  parameter logic [DATA_BITS-1:0] THRESH_HI = DATA_BITS'(ThreshHiDefault),
  parameter logic [DATA_BITS-1:0] THRESH_LO = DATA_BITS'(ThreshLoDefault)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] sample,
  input  logic                 strobe,
  output logic                 over_thresh
);

  logic over_q, over_d;

  // Between the two levels the flag keeps its previous value.
  always_comb begin
    over_d = over_q;
    if (strobe) begin
      if (sample >= THRESH_HI) begin
        over_d = 1'b1;
      end else if (sample < THRESH_LO) begin
        over_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      over_q <= 1'b0;
    end else begin
      over_q <= over_d;
    end
  end

  assign over_thresh = over_q;

endmodule

// File: rtl/adc_sampler.sv
// Serial ADC front end: generates cs/sclk framing, deserialises each conversion and
// presents it as a one-cycle-valid sample with lead-bit check and envelope flag.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int unsigned          CLK_DIV      = 2,
  parameter int unsigned          FRAME_BITS   = FrameBits,
  parameter int unsigned          DATA_BITS    = DataBits,
  parameter int unsigned          QUIET_CYCLES = 6,
  parameter logic [DATA_BITS-1:0] THRESH_HI    = DATA_BITS'(ThreshHiDefault),
  parameter logic [DATA_BITS-1:0] THRESH_LO    = DATA_BITS'(ThreshLoDefault)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic                 adc_cs,
  output logic                 adc_clk,
  input  logic                 adc_so,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 lead_err,
  output logic                 over_thresh
);

  localparam int unsigned DivMax = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int unsigned DivW   = $clog2(DivMax + 1);
  localparam int unsigned BitW   = $clog2(FRAME_BITS);

  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] QuietLast = DivW'(QUIET_CYCLES - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic [DATA_BITS-1:0]  sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  lead_q, lead_d;
  logic                  div_done;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    sample_d = sample_q;
    lead_d   = lead_q;
    valid_d  = 1'b0;
    div_done = (div_q == DivLast);
    case (state_q)
      StIdle: begin
        div_d  = '0;
        cs_d   = 1'b1;
        sclk_d = 1'b1;
        if (en) begin
          state_d = StSetup;
          cs_d    = 1'b0;
        end
      end
      StSetup: begin
        if (div_done) begin
          state_d = StLow;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      StLow: begin
        // Capturing on the last low cycle lines up with the ADC's rising-edge sample point.
        if (div_done) begin
          state_d = StHigh;
          div_d   = '0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[FRAME_BITS-2:0], adc_so};
        end
      end
      StHigh: begin
        if (div_done) begin
          div_d = '0;
          if (bit_q != BitLast) begin
            state_d = StLow;
            bit_d   = bit_q + 1'b1;
            sclk_d  = 1'b0;
          end else begin
            state_d  = StQuiet;
            cs_d     = 1'b1;
            sample_d = shift_q[DATA_BITS-1:0];
            lead_d   = |shift_q[FRAME_BITS-1:DATA_BITS];
            valid_d  = 1'b1;
          end
        end
      end
      StQuiet: begin
        if (div_q == QuietLast) begin
          div_d = '0;
          if (en) begin
            state_d = StSetup;
            cs_d    = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      lead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      lead_q   <= lead_d;
    end
  end

  // Fed with next-state values so the flag updates on the same edge as sample_valid.
  adc_hyst_cmp #(
    .DATA_BITS (DATA_BITS),
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_hyst (
    .clk         (clk),
    .reset       (reset),
    .sample      (sample_d),
    .strobe      (valid_d),
    .over_thresh (over_thresh)
  );

  assign adc_cs       = cs_q;
  assign adc_clk      = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign lead_err     = lead_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Scoreboard bench for adc_sampler: ADC serial model, expected-sample queue, timing checks,
// plus a second instance at CLK_DIV=1 / QUIET_CYCLES=1.
module tb_adc_sampler;

  typedef struct {
    logic [11:0] s;
    logic        l;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic        adc_so;
  logic        adc_cs;
  logic        adc_clk;
  logic [11:0] sample;
  logic        sample_valid;
  logic        lead_err;
  logic        over_thresh;

  logic        f_so;
  logic        f_cs;
  logic        f_clk;
  logic [11:0] f_sample;
  logic        f_valid;
  logic        f_lead;
  logic        f_ot;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int cyc     = 0;
  int tmo_cnt = 0;
  int tmo_ack = 0;
  logic idle_expect;

  logic [15:0] dir_frames [8] = '{16'h0A5C, 16'd1000, 16'd2048, 16'd1800,
                                  16'd1535, 16'd1600, 16'h2123, 16'h0A5C};
  logic [15:0] fast_frame = 16'h0A5C;

  adc_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .adc_cs       (adc_cs),
    .adc_clk      (adc_clk),
    .adc_so       (adc_so),
    .sample       (sample),
    .sample_valid (sample_valid),
    .lead_err     (lead_err),
    .over_thresh  (over_thresh)
  );

  adc_sampler #(
    .CLK_DIV      (1),
    .QUIET_CYCLES (1)
  ) dut_fast (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .adc_cs       (f_cs),
    .adc_clk      (f_clk),
    .adc_so       (f_so),
    .sample       (f_sample),
    .sample_valid (f_valid),
    .lead_err     (f_lead),
    .over_thresh  (f_ot)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ADC models, scoreboard and monitors, all sampled on the falling clk edge.
  exp_t        exp_q [$];
  exp_t        e;
  logic [15:0] frame;
  logic [11:0] rd;
  logic [3:0]  rl;
  int          dir_idx = 0;
  int          ptr = -1;
  int          f_ptr = -1;
  int          last_fall = -1;
  int          f_last_fall = -1;
  int          rst_cyc = 0;
  logic        first_after_rst = 1'b0;
  logic        gap = 1'b1;
  logic        f_gap = 1'b1;
  logic        ref_ot = 1'b0;
  logic [11:0] held_s = '0;
  logic        held_l = 1'b0;
  logic        held_o = 1'b0;
  logic        rst_prev = 1'b1;
  logic        cs_prev = 1'b1;
  logic        aclk_prev = 1'b1;
  logic        valid_prev = 1'b0;
  logic        f_cs_prev = 1'b1;
  logic        f_clk_prev = 1'b1;

  initial begin
    adc_so = 1'b0;
    f_so   = 1'b0;
    forever begin
      @(negedge clk);
      if (tmo_cnt != tmo_ack) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wait_timeout: got %0d expired waits expected 0", tmo_cnt - tmo_ack);
        tmo_ack = tmo_cnt;
      end
      if (!rst_prev) begin
        chk("rst_cs", adc_cs, 1);
        chk("rst_clk", adc_clk, 1);
        chk("rst_valid", sample_valid, 0);
        chk("rst_sample", sample, 0);
        chk("rst_lead", lead_err, 0);
        chk("rst_ot", over_thresh, 0);
        chk("fast_rst_cs", f_cs, 1);
        chk("fast_rst_valid", f_valid, 0);
        exp_q.delete();
        ref_ot = 1'b0;
        held_s = '0;
        held_l = 1'b0;
        held_o = 1'b0;
        gap = 1'b1;
        f_gap = 1'b1;
        rst_cyc = cyc;
        first_after_rst = 1'b1;
      end else begin
        if (cs_prev && !adc_cs) begin
          if (dir_idx < 8) begin
            frame = dir_frames[dir_idx];
            dir_idx++;
          end else begin
            rd = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(1400, 2200))
                                             : 12'($urandom_range(0, 4095));
            rl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            frame = {rl, rd};
          end
          ptr = 15;
          exp_q.push_back('{s: frame[11:0], l: |frame[15:12]});
          if (first_after_rst) chk("cs_fall_after_en", cyc - rst_cyc, 1);
          first_after_rst = 1'b0;
          if (!gap && last_fall >= 0) chk("frame_period", cyc - last_fall, 72);
          gap = 1'b0;
          last_fall = cyc;
        end
        if (!adc_cs && aclk_prev && !adc_clk && ptr >= 0) begin
          adc_so = frame[ptr];
          ptr--;
        end
        if (sample_valid) begin
          n_valid++;
          chk("valid_latency", cyc - last_fall, 66);
          chk("cs_high_at_valid", adc_cs, 1);
          chk("valid_one_cycle", valid_prev, 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: got sample %0d expected no valid", sample);
          end else begin
            e = exp_q.pop_front();
            if (e.s >= 12'd2048) ref_ot = 1'b1;
            else if (e.s < 12'd1536) ref_ot = 1'b0;
            chk("sample", sample, e.s);
            chk("lead_err", lead_err, e.l);
            chk("over_thresh", over_thresh, ref_ot);
            held_s = e.s;
            held_l = e.l;
            held_o = ref_ot;
          end
        end else begin
          chk("sample_hold", sample, held_s);
          chk("lead_hold", lead_err, held_l);
          chk("ot_hold", over_thresh, held_o);
        end
        if (idle_expect) begin
          chk("idle_cs", adc_cs, 1);
          chk("idle_clk", adc_clk, 1);
          chk("idle_valid", sample_valid, 0);
        end
        // Fast instance always converts the same word.
        if (f_cs_prev && !f_cs) begin
          f_ptr = 15;
          if (!f_gap && f_last_fall >= 0) chk("fast_period", cyc - f_last_fall, 34);
          f_gap = 1'b0;
          f_last_fall = cyc;
        end
        if (!f_cs && f_clk_prev && !f_clk && f_ptr >= 0) begin
          f_so = fast_frame[f_ptr];
          f_ptr--;
        end
        if (f_valid) begin
          chk("fast_latency", cyc - f_last_fall, 33);
          chk("fast_sample", f_sample, 'hA5C);
          chk("fast_lead", f_lead, 0);
        end
      end
      if (!en || !reset) begin
        gap = 1'b1;
        f_gap = 1'b1;
      end
      rst_prev   = reset;
      cs_prev    = adc_cs;
      aclk_prev  = adc_clk;
      valid_prev = sample_valid;
      f_cs_prev  = f_cs;
      f_clk_prev = f_clk;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valids(input int n, input int max_cyc);
    int target;
    target = n_valid + n;
    for (int i = 0; i < max_cyc && n_valid < target; i++) step();
    if (n_valid < target) tmo_cnt++;
  endtask

  task automatic wait_cs_fall(input int max_cyc);
    logic prev;
    logic seen;
    prev = adc_cs;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step();
      if (prev && !adc_cs) seen = 1'b1;
      prev = adc_cs;
    end
    if (!seen) tmo_cnt++;
  endtask

  task automatic wait_clk_falls(input int n, input int max_cyc);
    logic prev;
    int   falls;
    prev = adc_clk;
    falls = 0;
    for (int i = 0; i < max_cyc && falls < n; i++) begin
      step();
      if (prev && !adc_clk) falls++;
      prev = adc_clk;
    end
    if (falls < n) tmo_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b1;
    idle_expect = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    wait_valids(20, 20 * 80 + 200);

    // Drop en mid-frame: that frame must still complete, then the sampler idles.
    wait_cs_fall(200);
    repeat (19) step();
    en = 1'b0;
    wait_valids(1, 200);
    repeat (10) step();
    idle_expect = 1'b1;
    repeat (150) step();
    idle_expect = 1'b0;
    en = 1'b1;
    wait_valids(1, 200);

    // Abort a frame with reset during its 8th low phase.
    wait_cs_fall(200);
    wait_clk_falls(8, 200);
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_valids(3, 400);

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
